// File: rtl/slv_guard_rst_ctrl_pkg.sv
// Shared types for the guarded-subordinate reset controller.
//
// Holds the controller state encoding and the default-width cycle counter
// type. When SLV_GUARD_RST_LOCKOUT_EN is defined the state set gains a
// terminal LOCKOUT state that stops further recoveries.
package slv_guard_rst_ctrl_pkg;

    localparam int unsigned CntWidthDefault = 16;

    // Default-width cycle counter / budget type.
    typedef logic [CntWidthDefault-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_RESET,
        ST_SETTLE,
        ST_CLEAR
`ifdef SLV_GUARD_RST_LOCKOUT_EN
        , ST_LOCKOUT
`endif
    } rst_state_e;

endpackage

// File: rtl/slv_guard_rst_cnt.sv
// Loadable down-counter with zero flag, shared by the drain, reset-pulse and
// settle phases of the reset controller.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (count returns to 0)
//   load_i      load load_val_i this cycle (wins over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one, holding at zero
//   zero_o      count is zero
module slv_guard_rst_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Load takes priority; decrement never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer for a guarded AXI subordinate.
//
// On a guard reset request the port is isolated, in-flight traffic is given a
// bounded time to drain, the subordinate reset is pulsed, the block is given
// time to settle, and finally the port is handed back and the guards' request
// state is cleared with a one-cycle pulse.
//
// Optional feature macro: SLV_GUARD_RST_LOCKOUT_EN
//   Adds parameter MaxRecoveries and output lockout_o. Once MaxRecoveries
//   recoveries have completed, the next request parks the controller in a
//   permanent isolated LOCKOUT state until rst_ni.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   ctrl_ena_i         enable; requests are ignored in IDLE while low
//   guard_rst_req_i    level reset request from the guards
//   pending_i          subordinate still has outstanding transactions
//   drain_budget_i     maximum drain wait cycles
//   rst_len_i          subordinate reset pulse length (0 behaves as 1)
//   settle_i           post-reset settle cycles (0 behaves as 1)
//   isolate_o          gate AXI request/response paths
//   sub_rst_no         active-low reset to the subordinate
//   rst_clear_o        one-cycle pulse clearing guard reset request state
//   busy_o             controller not idle
//   drain_timeout_o    sticky: last drain ran out of budget
//   rec_cnt_o          completed recoveries, saturating
//   lockout_o          (feature only) recovery limit reached
module slv_guard_rst_ctrl
    import slv_guard_rst_ctrl_pkg::*;
#(
    parameter int unsigned CntWidth = $bits(cnt_t),
    parameter int unsigned RecWidth = 8
`ifdef SLV_GUARD_RST_LOCKOUT_EN
    , parameter int unsigned MaxRecoveries = 3
`endif
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ctrl_ena_i,
    input  logic                guard_rst_req_i,
    input  logic                pending_i,
    input  logic [CntWidth-1:0] drain_budget_i,
    input  logic [CntWidth-1:0] rst_len_i,
    input  logic [CntWidth-1:0] settle_i,
    output logic                isolate_o,
    output logic                sub_rst_no,
    output logic                rst_clear_o,
    output logic                busy_o,
    output logic                drain_timeout_o,
    output logic [RecWidth-1:0] rec_cnt_o
`ifdef SLV_GUARD_RST_LOCKOUT_EN
    , output logic              lockout_o
`endif
);

    rst_state_e          state_q, state_d;
    logic                isolate_q, isolate_d;
    logic                subRstN_q, subRstN_d;
    logic                rstClear_q, rstClear_d;
    logic                drainTimeout_q, drainTimeout_d;
    logic [RecWidth-1:0] recCnt_q, recCnt_d;
    logic                cntLoad, cntDec, cntZero;
    logic [CntWidth-1:0] cntLoadVal;
    logic                timeoutSet, timeoutClr;
`ifdef SLV_GUARD_RST_LOCKOUT_EN
    logic                lockout_q, lockout_d;
`endif

    // A phase of N cycles is counted as N-1 down to 0; length 0 is one cycle.
    function automatic logic [CntWidth-1:0] lenToCnt(input logic [CntWidth-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    slv_guard_rst_cnt #(
        .Width (CntWidth)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cntLoad),
        .load_val_i (cntLoadVal),
        .dec_i      (cntDec),
        .zero_o     (cntZero)
    );

    // Next-state logic. Phase lengths are loaded into the counter on the
    // transition into each phase, so input changes mid-phase are ignored.
    always_comb begin
        state_d    = state_q;
        cntLoad    = 1'b0;
        cntLoadVal = '0;
        cntDec     = 1'b0;
        timeoutSet = 1'b0;
        timeoutClr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_ena_i && guard_rst_req_i) begin
`ifdef SLV_GUARD_RST_LOCKOUT_EN
                    if (recCnt_q >= RecWidth'(MaxRecoveries)) begin
                        state_d = ST_LOCKOUT;
                    end else
`endif
                    begin
                        state_d    = ST_ISOLATE;
                        cntLoad    = 1'b1;
                        cntLoadVal = drain_budget_i;
                        timeoutClr = 1'b1;
                    end
                end
            end
            ST_ISOLATE: begin
                if (!pending_i || cntZero) begin
                    state_d    = ST_RESET;
                    cntLoad    = 1'b1;
                    cntLoadVal = lenToCnt(rst_len_i);
                    timeoutSet = pending_i;
                end else begin
                    cntDec = 1'b1;
                end
            end
            ST_RESET: begin
                if (cntZero) begin
                    state_d    = ST_SETTLE;
                    cntLoad    = 1'b1;
                    cntLoadVal = lenToCnt(settle_i);
                end else begin
                    cntDec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cntZero) begin
                    state_d = ST_CLEAR;
                end else begin
                    cntDec = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
`ifdef SLV_GUARD_RST_LOCKOUT_EN
            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs are decoded from the next state and registered, so they
    // change together with the state register.
    always_comb begin
        isolate_d      = (state_d != ST_IDLE);
        subRstN_d      = (state_d != ST_RESET);
        rstClear_d     = (state_d == ST_CLEAR);
        drainTimeout_d = drainTimeout_q;
        if (timeoutClr) begin
            drainTimeout_d = 1'b0;
        end else if (timeoutSet) begin
            drainTimeout_d = 1'b1;
        end
        recCnt_d = recCnt_q;
        if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR) && (recCnt_q != '1)) begin
            recCnt_d = recCnt_q + 1'b1;
        end
`ifdef SLV_GUARD_RST_LOCKOUT_EN
        lockout_d = lockout_q | (state_d == ST_LOCKOUT);
`endif
    end

    // State and output registers; reset releases the subordinate reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            isolate_q      <= 1'b0;
            subRstN_q      <= 1'b1;
            rstClear_q     <= 1'b0;
            drainTimeout_q <= 1'b0;
            recCnt_q       <= '0;
`ifdef SLV_GUARD_RST_LOCKOUT_EN
            lockout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            isolate_q      <= isolate_d;
            subRstN_q      <= subRstN_d;
            rstClear_q     <= rstClear_d;
            drainTimeout_q <= drainTimeout_d;
            recCnt_q       <= recCnt_d;
`ifdef SLV_GUARD_RST_LOCKOUT_EN
            lockout_q      <= lockout_d;
`endif
        end
    end

    assign isolate_o       = isolate_q;
    assign sub_rst_no      = subRstN_q;
    assign rst_clear_o     = rstClear_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign drain_timeout_o = drainTimeout_q;
    assign rec_cnt_o       = recCnt_q;
`ifdef SLV_GUARD_RST_LOCKOUT_EN
    assign lockout_o       = lockout_q;
`endif

endmodule
